pp_shift_add_mult: RTL

PP_SHIFT_ADD_MULT -- requirements
Module: pp_shift_add_mult

---
 rtl/pp_shift_add_mult.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pp_shift_add_mult.sv
// ============================================================================
// Module   : pp_shift_add_mult
// Purpose  : Sequential shift-and-add unsigned multiplier, one partial product
//            per cycle, valid/ready handshakes on both sides.
//            Optional macro PP_PARITY_EN adds the product_par output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
`ifdef PP_PARITY_EN
  ,
  output logic               product_par
`endif
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplr;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  // The multiplicand is pre-shifted and the multiplier consumed LSB-first,
  // so bit i of b gates a<<i on cycle i without a variable shifter.
  assign w_pp   = r_mcand & {(2*WIDTH){r_mplr[0]}};
  assign w_sum  = r_acc + w_pp;
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_CALC;
      S_CALC:  if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= {{WIDTH{1'b0}}, a};
            r_mplr  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_acc   <= w_sum;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          if (w_last) begin
            r_cnt     <= '0;
            r_product <= w_sum;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PP_PARITY_EN
  logic r_product_par;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_product_par <= 1'b0;
    end else if (r_state == S_CALC && w_last) begin
      r_product_par <= ^w_sum;
    end
  end

  assign product_par = r_product_par;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

endmodule

`default_nettype wire
